// File: rtl/turn_ctrl.sv
// Turn sequencer for a two-player timed game: IDLE -> ARM -> RUN -> OVER, with move/strike counters.
// Latency: all outputs are registered state or decodes of state; each move or accepted timeout costs one ARM cycle.
// Backpressure: none; events outside RUN are dropped. Timeout strikes/forfeit only with TURN_CTRL_STRIKES_EN.
module turn_ctrl #(
  parameter int MAX_STRIKES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       move_valid,
  input  logic       extra_turn,
  input  logic       goal,
  input  logic       time_expire,
  output logic       timer_start,
  output logic       timer_rst,
  output logic       player,
  output logic       turn_active,
  output logic [1:0] strikes0,
  output logic [1:0] strikes1,
  output logic [7:0] move_count,
  output logic       game_over,
  output logic       winner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  if (MAX_STRIKES < 1 || MAX_STRIKES > 3) begin : g_bad_max_strikes
    $error("turn_ctrl: MAX_STRIKES must be in 1..3");
  end

  logic [1:0] state_q, state_d;
  logic       player_q, player_d;
  logic       winner_q, winner_d;
  logic [7:0] move_count_q, move_count_d;

`ifdef TURN_CTRL_STRIKES_EN
  localparam logic [1:0] STRIKE_LIMIT = 2'(MAX_STRIKES);
  logic [1:0] strikes0_q, strikes0_d;
  logic [1:0] strikes1_q, strikes1_d;
  logic [1:0] strike_new;
`endif

  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    winner_d     = winner_q;
    move_count_d = move_count_q;
`ifdef TURN_CTRL_STRIKES_EN
    strikes0_d   = strikes0_q;
    strikes1_d   = strikes1_q;
    strike_new   = player_q ? strikes1_q + 2'd1 : strikes0_q + 2'd1;
`endif
    case (state_q)
      S_IDLE, S_OVER: begin
        if (game_start) begin
          state_d      = S_ARM;
          player_d     = 1'b0;
          winner_d     = 1'b0;
          move_count_d = 8'd0;
`ifdef TURN_CTRL_STRIKES_EN
          strikes0_d   = 2'd0;
          strikes1_d   = 2'd0;
`endif
        end
      end
      S_ARM: state_d = S_RUN;
      default: begin
        // Priority goal > move > timeout; a move in the same cycle as a timeout wins.
        if (goal) begin
          state_d  = S_OVER;
          winner_d = player_q;
        end else if (move_valid) begin
          state_d = S_ARM;
          if (move_count_q != 8'hFF) move_count_d = move_count_q + 8'd1;
          if (!extra_turn) player_d = ~player_q;
        end else if (time_expire) begin
`ifdef TURN_CTRL_STRIKES_EN
          if (player_q) strikes1_d = strike_new;
          else          strikes0_d = strike_new;
          if (strike_new == STRIKE_LIMIT) begin
            state_d  = S_OVER;
            winner_d = ~player_q;
          end else begin
            state_d  = S_ARM;
            player_d = ~player_q;
          end
`else
          state_d  = S_ARM;
          player_d = ~player_q;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      player_q     <= 1'b0;
      winner_q     <= 1'b0;
      move_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      winner_q     <= winner_d;
      move_count_q <= move_count_d;
    end
  end

`ifdef TURN_CTRL_STRIKES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strikes0_q <= 2'd0;
      strikes1_q <= 2'd0;
    end else begin
      strikes0_q <= strikes0_d;
      strikes1_q <= strikes1_d;
    end
  end
  assign strikes0 = strikes0_q;
  assign strikes1 = strikes1_q;
`else
  assign strikes0 = 2'd0;
  assign strikes1 = 2'd0;
`endif

  assign timer_start = (state_q == S_RUN);
  assign turn_active = (state_q == S_RUN);
  assign timer_rst   = (state_q != S_RUN);
  assign game_over   = (state_q == S_OVER);
  assign player      = player_q;
  assign winner      = winner_q;
  assign move_count  = move_count_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Bench for turn_ctrl: vector table, hand-written corner sequences and random traffic against a game model.
module tb_turn_ctrl;

  localparam int MAXS = 2;
`ifdef TURN_CTRL_STRIKES_EN
  localparam bit STRIKES_EN = 1'b1;
`else
  localparam bit STRIKES_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic game_start = 1'b0, move_valid = 1'b0, extra_turn = 1'b0, goal = 1'b0, time_expire = 1'b0;
  logic timer_start, timer_rst, player, turn_active, game_over, winner;
  logic [1:0] strikes0, strikes1;
  logic [7:0] move_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_ctrl #(.MAX_STRIKES(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .move_valid(move_valid),
    .extra_turn(extra_turn), .goal(goal), .time_expire(time_expire),
    .timer_start(timer_start), .timer_rst(timer_rst), .player(player),
    .turn_active(turn_active), .strikes0(strikes0), .strikes1(strikes1),
    .move_count(move_count), .game_over(game_over), .winner(winner)
  );

  // Game model: a game is "live" between start and end; "arming" marks the timer-restart cycle.
  bit m_live, m_arming, m_over, m_player, m_winner;
  int m_moves;
  int m_strikes[2];

  function automatic void model_reset();
    m_live = 0; m_arming = 0; m_over = 0; m_player = 0; m_winner = 0;
    m_moves = 0; m_strikes[0] = 0; m_strikes[1] = 0;
  endfunction

  function automatic void model_step(bit gs, bit mv, bit et, bit gl, bit te);
    if (!m_live) begin
      if (gs) begin
        model_reset();
        m_live = 1; m_arming = 1;
      end
    end else if (m_arming) begin
      m_arming = 0;
    end else if (gl) begin
      m_live = 0; m_over = 1; m_winner = m_player;
    end else if (mv) begin
      m_moves = (m_moves < 255) ? m_moves + 1 : 255;
      if (!et) m_player = !m_player;
      m_arming = 1;
    end else if (te) begin
      if (STRIKES_EN) begin
        m_strikes[m_player] = m_strikes[m_player] + 1;
        if (m_strikes[m_player] == MAXS) begin
          m_live = 0; m_over = 1; m_winner = !m_player;
        end else begin
          m_player = !m_player; m_arming = 1;
        end
      end else begin
        m_player = !m_player; m_arming = 1;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    bit running;
    running = m_live && !m_arming;
    chk({tag, ".timer_start"}, int'(timer_start), int'(running));
    chk({tag, ".timer_rst"},   int'(timer_rst),   int'(!running));
    chk({tag, ".turn_active"}, int'(turn_active), int'(running));
    chk({tag, ".player"},      int'(player),      int'(m_player));
    chk({tag, ".game_over"},   int'(game_over),   int'(m_over));
    chk({tag, ".winner"},      int'(winner),      int'(m_winner));
    chk({tag, ".move_count"},  int'(move_count),  m_moves);
    chk({tag, ".strikes0"},    int'(strikes0),    m_strikes[0]);
    chk({tag, ".strikes1"},    int'(strikes1),    m_strikes[1]);
  endtask

  task automatic cycle(input string tag, input bit gs, input bit mv, input bit et, input bit gl, input bit te);
    game_start = gs; move_valid = mv; extra_turn = et; goal = gl; time_expire = te;
    @(posedge clk);
    model_step(gs, mv, et, gl, te);
    #1;
    game_start = 0; move_valid = 0; extra_turn = 0; goal = 0; time_expire = 0;
    chk_model(tag);
  endtask

  typedef struct {
    bit gs, mv, et, gl, te;
    bit p, act, ov, win;
    int cnt;
  } vec_t;

  vec_t tbl[19];

  initial begin
    tbl[0]  = '{1,0,0,0,0, 0,0,0,0, 0};  // start -> ARM
    tbl[1]  = '{0,0,0,0,0, 0,1,0,0, 0};  // RUN
    tbl[2]  = '{0,1,0,0,0, 1,0,0,0, 1};
    tbl[3]  = '{0,0,0,0,0, 1,1,0,0, 1};
    tbl[4]  = '{0,1,0,0,0, 0,0,0,0, 2};
    tbl[5]  = '{0,0,0,0,0, 0,1,0,0, 2};
    tbl[6]  = '{0,1,0,0,0, 1,0,0,0, 3};
    tbl[7]  = '{0,0,0,0,0, 1,1,0,0, 3};
    tbl[8]  = '{0,1,1,0,0, 1,0,0,0, 4};  // extra turn keeps player
    tbl[9]  = '{0,0,0,0,0, 1,1,0,0, 4};
    tbl[10] = '{0,1,0,0,1, 0,0,0,0, 5};  // move beats timeout
    tbl[11] = '{0,0,0,0,1, 0,1,0,0, 5};  // stale timeout in ARM ignored
    tbl[12] = '{1,0,0,0,0, 0,1,0,0, 5};  // start ignored in RUN
    tbl[13] = '{0,1,0,0,0, 1,0,0,0, 6};
    tbl[14] = '{0,0,0,0,0, 1,1,0,0, 6};
    tbl[15] = '{0,0,0,1,1, 1,0,1,1, 6};  // goal beats timeout
    tbl[16] = '{0,1,0,0,1, 1,0,1,1, 6};  // events ignored in OVER
    tbl[17] = '{1,0,0,0,0, 0,0,0,0, 0};  // restart clears
    tbl[18] = '{0,0,0,0,0, 0,1,0,0, 0};

    model_reset();
    #12;
    chk("rst.timer_rst", int'(timer_rst), 1);
    chk("rst.player", int'(player), 0);
    chk("rst.game_over", int'(game_over), 0);
    chk("rst.move_count", int'(move_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("idle", 0, 1, 0, 1, 1);

    for (int i = 0; i < 19; i++) begin
      cycle($sformatf("tbl%0d", i), tbl[i].gs, tbl[i].mv, tbl[i].et, tbl[i].gl, tbl[i].te);
      chk($sformatf("tbl%0d.player", i),      int'(player),      int'(tbl[i].p));
      chk($sformatf("tbl%0d.turn_active", i), int'(turn_active), int'(tbl[i].act));
      chk($sformatf("tbl%0d.timer_rst", i),   int'(timer_rst),   int'(!tbl[i].act));
      chk($sformatf("tbl%0d.game_over", i),   int'(game_over),   int'(tbl[i].ov));
      chk($sformatf("tbl%0d.winner", i),      int'(winner),      int'(tbl[i].win));
      chk($sformatf("tbl%0d.move_count", i),  int'(move_count),  tbl[i].cnt);
      chk($sformatf("tbl%0d.strikes1", i),    int'(strikes1),    0);
    end

    // Timeout, opponent move, timeout again from RUN with player 0.
    cycle("to1", 0, 0, 0, 0, 1);
    cycle("to2", 0, 0, 0, 0, 0);
    cycle("to3", 0, 1, 0, 0, 0);
    cycle("to4", 0, 0, 0, 0, 0);
    cycle("to5", 0, 0, 0, 0, 1);
`ifdef TURN_CTRL_STRIKES_EN
    chk("forfeit.game_over", int'(game_over), 1);
    chk("forfeit.winner", int'(winner), 1);
    chk("forfeit.strikes0", int'(strikes0), 2);
`else
    chk("notimeout.game_over", int'(game_over), 0);
    chk("notimeout.player", int'(player), 1);
    chk("notimeout.strikes0", int'(strikes0), 0);
`endif

    // Move counter saturation.
    cycle("sat.g", 0, 0, 0, 1, 0);
    cycle("sat.s", 1, 0, 0, 0, 0);
    cycle("sat.r", 0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) begin
      cycle("sat.m", 0, 1, $urandom_range(0, 1), 0, 0);
      cycle("sat.a", 0, 0, 0, 0, 0);
    end
    chk("sat.move_count", int'(move_count), 255);

    // Asynchronous reset between edges mid-RUN.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.timer_rst", int'(timer_rst), 1);
    chk("arst.timer_start", int'(timer_start), 0);
    chk("arst.turn_active", int'(turn_active), 0);
    chk("arst.player", int'(player), 0);
    chk("arst.move_count", int'(move_count), 0);
    chk("arst.game_over", int'(game_over), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("arst.idle", 0, 1, 0, 0, 0);
    cycle("arst.start", 1, 0, 0, 0, 0);
    chk("arst.start.move_count", int'(move_count), 0);
    chk("arst.start.timer_rst", int'(timer_rst), 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd",
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
